rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 135 +++++++++++++
 tb/tb_rom_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a combinational boot ROM.
// One access is in flight at a time; responses return on the port that was granted.
module rom_arbiter #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE    = 32'hBFC00000,
    parameter int                    ROM_BYTES   = 4096,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_err_o,

    input  logic                  ld_req_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    output logic                  ld_gnt_o,
    output logic                  ld_rvalid_o,
    output logic [DATA_WIDTH-1:0] ld_rdata_o,
    output logic                  ld_err_o,

    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i
);

    localparam int AW1 = ADDR_WIDTH + 1;
    // Highest legal word address, one bit wider so the bound cannot wrap.
    localparam logic [ADDR_WIDTH:0] ROM_LAST = {1'b0, ROM_BASE} + AW1'(ROM_BYTES) - AW1'(4);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    port_reg;
    logic                    last_reg;
    logic                    bad_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [1:0]              rvalid_reg;
    logic [1:0]              err_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg [2];

    logic [1:0]              req;
    logic [1:0]              gnt;
    logic                    grant_any;
    logic                    sel;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    addr_bad;
    logic                    done;

    assign req = {ld_req_i, if_req_i};

    always_comb begin
        grant_any = (state_reg == IDLE) && (req != 2'b00);
        // On a conflict the port that lost last time wins; a lone requester always wins.
        sel       = (req == 2'b11) ? ~last_reg : req[1];
        sel_addr  = sel ? ld_addr_i : if_addr_i;
        addr_bad  = (sel_addr[1:0] != 2'b00)
                 || (sel_addr < ROM_BASE)
                 || ({1'b0, sel_addr} > ROM_LAST);
        done      = (state_reg == ACCESS) && (cnt_reg == 4'd0);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign gnt[gi] = grant_any && (sel == 1'(gi));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rvalid_reg[gi] <= 1'b0;
                    err_reg[gi]    <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else if (done && (port_reg == 1'(gi))) begin
                    rvalid_reg[gi] <= 1'b1;
                    err_reg[gi]    <= bad_reg;
                    rdata_reg[gi]  <= bad_reg ? '0 : rom_data_i;
                end else begin
                    rvalid_reg[gi] <= 1'b0;
                    err_reg[gi]    <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            port_reg  <= 1'b0;
            last_reg  <= 1'b1;
            bad_reg   <= 1'b0;
            addr_reg  <= ROM_BASE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        port_reg  <= sel;
                        last_reg  <= sel;
                        addr_reg  <= sel_addr;
                        bad_reg   <= addr_bad;
                        cnt_reg   <= 4'(WAIT_STATES);
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign if_gnt_o    = gnt[0];
    assign ld_gnt_o    = gnt[1];
    assign if_rvalid_o = rvalid_reg[0];
    assign ld_rvalid_o = rvalid_reg[1];
    assign if_err_o    = err_reg[0];
    assign ld_err_o    = err_reg[1];
    assign if_rdata_o  = rdata_reg[0];
    assign ld_rdata_o  = rdata_reg[1];
    assign rom_addr_o  = addr_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: vector table plus hand sequences, responses checked
// against a scoreboard of expected rvalid events.
module tb_rom_arbiter;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, ld_req = 1'b0;
    logic [31:0] if_addr = '0, ld_addr = '0;
    logic        if_gnt, if_rvalid, if_err, ld_gnt, ld_rvalid, ld_err;
    logic [31:0] if_rdata, ld_rdata, rom_addr, rom_data;

    logic        z_req = 1'b0;
    logic [31:0] z_addr = '0;
    logic        z_gnt, z_rvalid, z_err, zl_gnt, zl_rvalid, zl_err;
    logic [31:0] z_rdata, zl_rdata, z_rom_addr, z_rom_data;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        if (a == BASE) return 32'h00000013;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    assign rom_data   = rom_fn(rom_addr);
    assign z_rom_data = rom_fn(z_rom_addr);

    rom_arbiter #(.WAIT_STATES(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_gnt_o(ld_gnt),
        .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata), .ld_err_o(ld_err),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data)
    );

    rom_arbiter #(.WAIT_STATES(0)) dut_z (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(z_req), .if_addr_i(z_addr), .if_gnt_o(z_gnt),
        .if_rvalid_o(z_rvalid), .if_rdata_o(z_rdata), .if_err_o(z_err),
        .ld_req_i(1'b0), .ld_addr_i(32'h0), .ld_gnt_o(zl_gnt),
        .ld_rvalid_o(zl_rvalid), .ld_rdata_o(zl_rdata), .ld_err_o(zl_err),
        .rom_addr_o(z_rom_addr), .rom_data_i(z_rom_data)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] model_rd [2] = '{32'h0, 32'h0};

    task automatic push_exp(input logic p, input logic [31:0] a, input logic bad);
        exp_t e;
        e.port = p;
        e.err  = bad;
        e.data = bad ? 32'h0 : rom_fn(a);
        e.due  = cyc + 3;
        sb.push_back(e);
    endtask

    // Response monitor for the WAIT_STATES=1 instance
    always @(negedge clk) begin
        logic        rv, er;
        logic [31:0] rd;
        exp_t        e;
        if (if_rvalid && ld_rvalid) check("dual_rvalid", 32'(ld_rvalid), 32'h0);
        for (int p = 0; p < 2; p++) begin
            rv = (p == 0) ? if_rvalid : ld_rvalid;
            rd = (p == 0) ? if_rdata  : ld_rdata;
            er = (p == 0) ? if_err    : ld_err;
            if (rv) begin
                if (sb.size() == 0) begin
                    check("spurious_rvalid", 32'(rv), 32'h0);
                end else begin
                    e = sb.pop_front();
                    $display("rvalid port %0d data %h err %0d cycle %0d", p, rd, er, cyc);
                    check("rsp_port",  32'(p), 32'(e.port));
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                    check("rsp_data",  rd, e.data);
                    check("rsp_err",   32'(er), 32'(e.err));
                    model_rd[p] = e.data;
                end
            end else begin
                check("rdata_hold", rd, model_rd[p]);
            end
        end
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check("rvalid_timeout", 32'(cyc), 32'(e.due));
        end
    end

    typedef struct {
        logic        rq_if;
        logic [31:0] a_if;
        logic        rq_ld;
        logic [31:0] a_ld;
        logic        exp_port;
        logic        exp_err;
    } vec_t;
    vec_t vecs [13];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'hBFC00000, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hBFC00004, 1'b1, 32'hBFC00010, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'hBFC00004, 1'b1, 32'hBFC00010, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'hBFC00020, 1'b1, 32'hBFC00024, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 32'hBFC00002, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 32'hBFC01000, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 32'hBFC00FFC, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'hBFC00001, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'hBFC00100, 1'b1, 32'hBFC00800, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 32'hBFBFFFFC, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'hBFC00FFC, 1'b1, 32'hBFC00FF8, 1'b1, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_rom_addr", rom_addr, BASE);
        check("rst_if_rvalid", 32'(if_rvalid), 32'h0);
        check("rst_ld_rvalid", 32'(ld_rvalid), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ld_rdata", ld_rdata, 32'h0);
        check("rst_if_err", 32'(if_err), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Table-driven transactions, one every WAIT_STATES+2 cycles
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if_req = vecs[i].rq_if; if_addr = vecs[i].a_if;
            ld_req = vecs[i].rq_ld; ld_addr = vecs[i].a_ld;
            #1;
            check("vec_if_gnt", 32'(if_gnt), 32'(vecs[i].exp_port == 1'b0));
            check("vec_ld_gnt", 32'(ld_gnt), 32'(vecs[i].exp_port == 1'b1));
            push_exp(vecs[i].exp_port, vecs[i].exp_port ? vecs[i].a_ld : vecs[i].a_if,
                     vecs[i].exp_err);
            for (int k = 0; k < 2; k++) begin
                @(negedge clk); #1;
                check("access_no_gnt", 32'({if_gnt, ld_gnt}), 32'h0);
            end
        end
        @(negedge clk);
        if_req = 1'b0; ld_req = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the cycle after a grant drops the access
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'hBFC00004;
        #1 check("pre_rst_if_gnt", 32'(if_gnt), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0;
        model_rd[0] = 32'h0; model_rd[1] = 32'h0;
        @(negedge clk);
        check("mid_rst_rom_addr", rom_addr, BASE);
        check("mid_rst_if_rdata", if_rdata, 32'h0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("post_rst_no_gnt", 32'({if_gnt, ld_gnt}), 32'h0);
        end

        // Both ports requesting continuously: if, ld, if, ld every 3 cycles
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'hBFC00004;
            ld_req = 1'b1; ld_addr = 32'hBFC00010;
            #1;
            check("rr_if_gnt", 32'(if_gnt), 32'(k % 6 == 0));
            check("rr_ld_gnt", 32'(ld_gnt), 32'(k % 6 == 3));
            if (k % 6 == 0) push_exp(1'b0, 32'hBFC00004, 1'b0);
            if (k % 6 == 3) push_exp(1'b1, 32'hBFC00010, 1'b0);
        end
        @(negedge clk);
        if_req = 1'b0; ld_req = 1'b0;
        repeat (5) @(negedge clk);

        // Zero wait states: grant every 2 cycles, rvalid 2 cycles after each grant
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            z_req = 1'b1; z_addr = 32'hBFC00008;
            #1;
            check("ws0_gnt", 32'(z_gnt), 32'(k % 2 == 0));
            check("ws0_rvalid", 32'(z_rvalid), 32'(k >= 2 && k % 2 == 0));
            if (z_rvalid) begin
                $display("ws0 rvalid data %h err %0d cycle %0d", z_rdata, z_err, cyc);
                check("ws0_rdata", z_rdata, rom_fn(32'hBFC00008));
                check("ws0_err", 32'(z_err), 32'h0);
            end
        end
        @(negedge clk);
        z_req = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
